irq_ctrl: RTL

//  Collects the interrupt sources (timer IRQs, external interrupt) and presents one at a time to the CPU.

---
 rtl/irq_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Interrupt controller. Collects N_SRC interrupt sources, latches
//            them into a pending register (edge or level mode per source),
//            arbitrates among enabled pending sources and presents one at a
//            time to the CPU as a one-hot HWInt vector. The vector is held
//            until the CPU acknowledges it. The controller then waits for
//            eret before presenting the next source (no nesting).
//            Software configuration and status are reached through a small
//            memory-mapped register file.
// Config   : IRQ_RR_EN defined   -> round-robin arbitration. The search
//                                   starts one past the last acknowledged id.
//            IRQ_RR_EN undefined -> fixed priority, lowest index wins.
// Ports    : clk      - system clock, all state on the rising edge
//            reset    - asynchronous reset, active low
//            irq_in   - raw interrupt source lines (synchronous to clk)
//            addr     - register select (byte address bits [3:2])
//                       0 ENABLE (RW), 1 PENDING (RO / W1C),
//                       2 EDGE (RW, 1 = rising edge), 3 STATUS (RO)
//            we       - register write strobe
//            wdata    - register write data
//            rdata    - register read data, combinational from addr
//            int_out  - one-hot presented interrupt to the CPU
//            int_id   - id of the presented / in-service source
//            int_ack  - CPU took the exception (one-cycle pulse)
//            eret     - CPU executed eret (one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [N_SRC-1:0] int_out,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack,
    input  logic             eret
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SVC  = 2'd2;

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_EDGE    = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

    // Architectural state
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] irq_prev;
    logic [1:0]       state;

    // Next-state / combinational helpers
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] enable_nxt;
    logic [N_SRC-1:0] edge_nxt;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] id_onehot;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             ack_take;
    logic             withdraw;
    logic             wr_enable;
    logic             wr_pending;
    logic             wr_edge;

    // Only the low N_SRC bits of wdata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:N_SRC];

    assign wr_enable  = we && (addr == A_ENABLE);
    assign wr_pending = we && (addr == A_PENDING);
    assign wr_edge    = we && (addr == A_EDGE);

    assign id_onehot = ONE_HOT0 << int_id;
    assign ack_take  = (state == ST_REQ) && int_ack;

    // Edge-mode sources set on a rising edge, level-mode sources while high.
    assign set_vec = irq_in & (~edge_mode | ~irq_prev);

    // W1C clears and the acknowledge clear; a coincident set overrides both.
    assign clr_vec = (wr_pending ? wdata[N_SRC-1:0] : '0) |
                     (ack_take ? id_onehot : '0);

    assign pending_nxt = set_vec | (pending & ~clr_vec);
    assign enable_nxt  = wr_enable ? wdata[N_SRC-1:0] : enable;
    assign edge_nxt    = wr_edge ? wdata[N_SRC-1:0] : edge_mode;

    // Arbitration uses the registered (pre-write) values.
    assign cand = pending & enable;

    // The presented request is withdrawn as soon as this cycle's update
    // removes it from the candidate set, so int_out drops on the next edge.
    assign withdraw = ~|(id_onehot & enable_nxt & pending_nxt);

`ifdef IRQ_RR_EN
    localparam int CW = ID_W + 1;

    logic [ID_W-1:0] rr_ptr;

    // Search order: rr_ptr+1, rr_ptr+2, ... wrapping modulo N_SRC.
    // The sum never reaches 2*N_SRC, so a single subtraction wraps it.
    always_comb begin
        logic [CW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = {1'b0, rr_ptr} + CW'(k);
            if (idx >= CW'(N_SRC)) begin
                idx = idx - CW'(N_SRC);
            end
            if (!found && cand[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (ack_take) begin
            rr_ptr <= int_id;
        end
    end
`else
    // Descending scan so the lowest pending index is the last assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable    <= '0;
            edge_mode <= '0;
            pending   <= '0;
            irq_prev  <= '0;
            int_out   <= '0;
            int_id    <= '0;
            state     <= ST_IDLE;
        end else begin
            enable    <= enable_nxt;
            edge_mode <= edge_nxt;
            pending   <= pending_nxt;
            irq_prev  <= irq_in;

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        int_id  <= winner;
                        int_out <= ONE_HOT0 << winner;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acknowledge takes precedence over a coincident withdraw.
                    if (int_ack) begin
                        int_out <= '0;
                        state   <= ST_SVC;
                    end else if (withdraw) begin
                        int_out <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SVC: begin
                    // int_id keeps the in-service id until the next decision.
                    if (eret) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    int_out <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_ENABLE:  rdata[N_SRC-1:0] = enable;
            A_PENDING: rdata[N_SRC-1:0] = pending;
            A_EDGE:    rdata[N_SRC-1:0] = edge_mode;
            A_STATUS: begin
                rdata[9:8]      = state;
                rdata[ID_W-1:0] = int_id;
            end
            default:   rdata = '0;
        endcase
    end

endmodule
`default_nettype wire
